// File: rtl/pbit_scheduler.sv
// Time-multiplexes one shared MAC across N_PBITS p-bits: each bit gets a settle cycle
// (ISSUE) and a sample cycle (UPDATE), with sweep counting and stepped I_0 annealing.
module pbit_scheduler #(
    parameter int N_PBITS          = 4,
    parameter int WEIGHT_PRECISION = 6,
    parameter int SEL_W            = 2
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    input  logic [7:0]                         sweeps,
    input  logic [3:0]                         i0_start,
    input  logic [7:0]                         i0_step,
    input  logic [N_PBITS-1:0]                 p_init,
    input  logic [N_PBITS-1:0]                 clamp_mask,
    input  logic [N_PBITS-1:0]                 clamp_val,
    input  logic signed [WEIGHT_PRECISION-1:0] mac_out,
    input  logic signed [WEIGHT_PRECISION-1:0] rnd,
    output logic [SEL_W-1:0]                   mac_sel,
    output logic [3:0]                         mac_I0,
    output logic [N_PBITS-1:0]                 p_state,
    output logic                               busy,
    output logic                               done
);

    typedef enum logic [1:0] {IDLE, ISSUE, UPDATE, DONE} state_t;

    state_t               state;
    logic [7:0]           sweeps_lat;
    logic [7:0]           sweep_cnt;
    logic [7:0]           i0_step_lat;
    logic [7:0]           step_cnt;
    logic [N_PBITS-1:0]   clamp_lat;

    // Stochastic neuron: fire when the local field beats the random sample; ties do not fire.
    function automatic logic sample_bit(
        input logic signed [WEIGHT_PRECISION-1:0] field,
        input logic signed [WEIGHT_PRECISION-1:0] noise
    );
        return field > noise;
    endfunction

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'd15) ? v : v + 4'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            p_state     <= '0;
            mac_sel     <= '0;
            mac_I0      <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            sweep_cnt   <= '0;
            step_cnt    <= '0;
            sweeps_lat  <= '0;
            i0_step_lat <= '0;
            clamp_lat   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        sweeps_lat  <= sweeps;
                        i0_step_lat <= i0_step;
                        clamp_lat   <= clamp_mask;
                        p_state     <= (p_init & ~clamp_mask) | (clamp_val & clamp_mask);
                        mac_sel     <= '0;
                        mac_I0      <= i0_start;
                        sweep_cnt   <= '0;
                        step_cnt    <= '0;
                        if (sweeps == 8'd0) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state <= ISSUE;
                            busy  <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    state <= UPDATE;
                end
                UPDATE: begin
                    if (!clamp_lat[mac_sel])
                        p_state[mac_sel] <= sample_bit(mac_out, rnd);
                    if (mac_sel == SEL_W'(N_PBITS - 1)) begin
                        mac_sel   <= '0;
                        sweep_cnt <= sweep_cnt + 8'd1;
                        // Anneal: raise I_0 once every i0_step completed sweeps.
                        if (i0_step_lat != 8'd0) begin
                            if (step_cnt + 8'd1 == i0_step_lat) begin
                                step_cnt <= '0;
                                mac_I0   <= sat_inc(mac_I0);
                            end else begin
                                step_cnt <= step_cnt + 8'd1;
                            end
                        end
                        if (sweep_cnt + 8'd1 == sweeps_lat) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state <= ISSUE;
                        end
                    end else begin
                        mac_sel <= mac_sel + SEL_W'(1);
                        state   <= ISSUE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pbit_scheduler.sv
// Directed and randomized bench for pbit_scheduler; expectations come from a
// per-cycle schedule model (bit = (t/2)%N, sweep = t/(2N)) rather than FSM state.
module tb_pbit_scheduler;

    localparam int N = 4;
    localparam int W = 6;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                start = 1'b0;
    logic [7:0]          sweeps = '0;
    logic [3:0]          i0_start = '0;
    logic [7:0]          i0_step = '0;
    logic [N-1:0]        p_init = '0;
    logic [N-1:0]        clamp_mask = '0;
    logic [N-1:0]        clamp_val = '0;
    logic signed [W-1:0] mac_out = '0;
    logic signed [W-1:0] rnd = '0;
    logic [1:0]          mac_sel;
    logic [3:0]          mac_I0;
    logic [N-1:0]        p_state;
    logic                busy;
    logic                done;

    int checks = 0;
    int failures = 0;

    pbit_scheduler #(.N_PBITS(N), .WEIGHT_PRECISION(W), .SEL_W(2)) dut (
        .clk(clk), .rst(rst), .start(start), .sweeps(sweeps), .i0_start(i0_start),
        .i0_step(i0_step), .p_init(p_init), .clamp_mask(clamp_mask), .clamp_val(clamp_val),
        .mac_out(mac_out), .rnd(rnd), .mac_sel(mac_sel), .mac_I0(mac_I0),
        .p_state(p_state), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic signed [W-1:0] pick();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 4))
            0: return -6'sd32;
            1: return 6'sd31;
            2: return -6'sd1;
            3: return 6'sd0;
            default: return r[W-1:0];
        endcase
    endfunction

    function automatic int i0_expect(input int i0s, input int stp, input int completed);
        int v;
        if (stp == 0) return i0s;
        v = i0s + completed / stp;
        return (v > 15) ? 15 : v;
    endfunction

    // One complete run; glitch >= 0 pulses start (with different settings) at that busy cycle.
    task automatic run(input int sw, input int i0s, input int stp,
                       input logic [N-1:0] pi, input logic [N-1:0] cm, input logic [N-1:0] cv,
                       input bit fixed, input logic signed [W-1:0] fm, input logic signed [W-1:0] fr,
                       input int glitch);
        logic [N-1:0] model;
        int b;
        model = (pi & ~cm) | (cv & cm);
        sweeps = sw[7:0]; i0_start = i0s[3:0]; i0_step = stp[7:0];
        p_init = pi; clamp_mask = cm; clamp_val = cv;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int t = 0; t < 2 * N * sw; t++) begin
            b = (t / 2) % N;
            if (fixed) begin mac_out = fm; rnd = fr; end
            else begin mac_out = pick(); rnd = pick(); end
            start = (t == glitch);
            if (t == glitch) begin sweeps = 8'd1; p_init = ~pi; i0_start = 4'd9; end
            check("run_mac_sel", 32'(mac_sel), 32'(b));
            check("run_busy", 32'(busy), 32'd1);
            check("run_done", 32'(done), 32'd0);
            check("run_mac_I0", 32'(mac_I0), 32'(i0_expect(i0s, stp, t / (2 * N))));
            check("run_p_state", 32'(p_state), 32'(model));
            if ((t % 2 == 1) && !cm[b]) model[b] = (mac_out > rnd);
            @(posedge clk); #1;
            start = 1'b0;
            p_init = pi; sweeps = sw[7:0]; i0_start = i0s[3:0];
        end
        check("end_done", 32'(done), 32'd1);
        check("end_busy", 32'(busy), 32'd0);
        check("end_p_state", 32'(p_state), 32'(model));
        check("end_mac_I0", 32'(mac_I0), 32'(i0_expect(i0s, stp, sw)));
        @(posedge clk); #1;
        check("idle_done", 32'(done), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_p_state", 32'(p_state), 32'(model));
        check("idle_mac_I0", 32'(mac_I0), 32'(i0_expect(i0s, stp, sw)));
        check("idle_mac_sel", 32'(mac_sel), 32'd0);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_p_state"}, 32'(p_state), 32'd0);
        check({tag, "_mac_sel"}, 32'(mac_sel), 32'd0);
        check({tag, "_mac_I0"}, 32'(mac_I0), 32'd0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check_reset_state("reset");

        // All-positive field: every bit fires, I_0 constant.
        run(1, 2, 0, 4'b0000, 4'b0000, 4'b0000, 1'b1, 6'sd5, 6'sd0, -1);
        check("all_fire", 32'(p_state), 32'hF);

        // Signed compare corners.
        run(1, 0, 0, 4'b1111, 4'b0000, 4'b0000, 1'b1, -6'sd3, -6'sd3, -1);
        check("tie_zero", 32'(p_state), 32'h0);
        run(1, 0, 0, 4'b0000, 4'b0000, 4'b0000, 1'b1, -6'sd2, -6'sd3, -1);
        check("neg_gt", 32'(p_state), 32'hF);
        run(1, 0, 0, 4'b1111, 4'b0000, 4'b0000, 1'b1, -6'sd32, 6'sd31, -1);
        check("min_vs_max", 32'(p_state), 32'h0);
        run(1, 0, 0, 4'b0000, 4'b0000, 4'b0000, 1'b1, 6'sd31, -6'sd32, -1);
        check("max_vs_min", 32'(p_state), 32'hF);

        // Clamped MSB survives a field that drives everything low.
        run(2, 0, 0, 4'b0111, 4'b1000, 4'b1000, 1'b1, -6'sd32, 6'sd0, -1);
        check("clamp_result", 32'(p_state), 32'h8);

        // I_0 annealing with saturation, and a slower step.
        run(4, 14, 1, 4'b0101, 4'b0000, 4'b0000, 1'b0, 6'sd0, 6'sd0, -1);
        run(5, 3, 2, 4'b1010, 4'b0010, 4'b0000, 1'b0, 6'sd0, 6'sd0, -1);

        // Zero sweeps: immediate done with the clamped initial vector.
        run(0, 7, 0, 4'b0110, 4'b0011, 4'b0001, 1'b0, 6'sd0, 6'sd0, -1);
        check("zero_sweeps_p", 32'(p_state), 32'h5);

        // start while busy is ignored.
        run(2, 1, 1, 4'b0011, 4'b0000, 4'b0000, 1'b0, 6'sd0, 6'sd0, 5);

        // Randomized runs.
        for (int k = 0; k < 12; k++)
            run($urandom_range(1, 6), $urandom_range(0, 15), $urandom_range(0, 3),
                4'($urandom), 4'($urandom), 4'($urandom), 1'b0, 6'sd0, 6'sd0,
                (k % 3 == 0) ? $urandom_range(0, 7) : -1);

        // Mid-run reset.
        sweeps = 8'd3; i0_start = 4'd6; i0_step = 8'd0; p_init = 4'b1111;
        clamp_mask = 4'b0000; clamp_val = 4'b0000;
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        check_reset_state("midrun_rst");

        // start coincident with reset is dropped.
        start = 1'b1; rst = 1'b1;
        @(posedge clk); #1 start = 1'b0; rst = 1'b0;
        check_reset_state("rst_start");
        @(posedge clk); #1;
        check("rst_start_busy2", 32'(busy), 32'd0);
        check("rst_start_done2", 32'(done), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
